// File: rtl/des_pkg.sv
// DES permutation constants: mode encodings and the FIPS 46-3 tables.
// Table entries are 1-based source-bit numbers in DES (MSB-first) order.
package des_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_IP  = 3'd0;
  localparam mode_t MODE_FP  = 3'd1;
  localparam mode_t MODE_E   = 3'd2;
  localparam mode_t MODE_P   = 3'd3;
  localparam mode_t MODE_PC1 = 3'd4;
  localparam mode_t MODE_PC2 = 3'd5;

  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int FP_TBL [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

endpackage

// File: rtl/des_perm_sel.sv
// Combinational DES permutation selector: applies the table chosen by mode_i
// to the right-aligned operand and flags illegal modes.
module des_perm_sel
  import des_pkg::*;
(
  input  logic [2:0]  mode_i,
  input  logic [63:0] din_i,
  output logic [63:0] perm_o,
  output logic        err_o
);

  // DES bit n (1-based, MSB-first) of a W-bit field lives at vector index W-n.
  logic [63:0] ip_w;
  logic [63:0] fp_w;
  logic [47:0] e_w;
  logic [31:0] p_w;
  logic [55:0] pc1_w;
  logic [47:0] pc2_w;

  for (genvar i = 0; i < 64; i++) begin : g_ipfp
    assign ip_w[63 - i] = din_i[64 - IP_TBL[i]];
    assign fp_w[63 - i] = din_i[64 - FP_TBL[i]];
  end

  for (genvar i = 0; i < 48; i++) begin : g_e_pc2
    assign e_w[47 - i]   = din_i[32 - E_TBL[i]];
    assign pc2_w[47 - i] = din_i[56 - PC2_TBL[i]];
  end

  for (genvar i = 0; i < 32; i++) begin : g_p
    assign p_w[31 - i] = din_i[32 - P_TBL[i]];
  end

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_w[55 - i] = din_i[64 - PC1_TBL[i]];
  end

  always_comb begin
    perm_o = '0;
    err_o  = 1'b0;
    case (mode_i)
      MODE_IP:  perm_o = ip_w;
      MODE_FP:  perm_o = fp_w;
      MODE_E:   perm_o = {16'h0000, e_w};
      MODE_P:   perm_o = {32'h0000_0000, p_w};
      MODE_PC1: perm_o = {8'h00, pc1_w};
      MODE_PC2: perm_o = {16'h0000, pc2_w};
      default:  err_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/des_perm_pipe.sv
// Pipelined DES permutation engine with valid/ready handshake; each slot
// carries {valid, data, tag, err} and bubbles collapse under back-pressure.
module des_perm_pipe
  import des_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       mode,
  input  logic [63:0]      din,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      dout,
  output logic [TAG_W-1:0] tag_out,
  output logic             err
);

  logic [63:0] perm;
  logic        perm_err;

  logic [STAGES-1:0]            valid_q, valid_d, load;
  logic [STAGES-1:0][63:0]      data_q, data_d;
  logic [STAGES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [STAGES-1:0]            err_q, err_d;

  des_perm_sel u_sel (
    .mode_i (mode),
    .din_i  (din),
    .perm_o (perm),
    .err_o  (perm_err)
  );

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    logic             src_valid;
    logic [63:0]      src_data;
    logic [TAG_W-1:0] src_tag;
    logic             src_err;

    if (k == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = perm;
      assign src_tag   = tag_in;
      assign src_err   = perm_err;
    end else begin : g_body
      assign src_valid = valid_q[k-1];
      assign src_data  = data_q[k-1];
      assign src_tag   = tag_q[k-1];
      assign src_err   = err_q[k-1];
    end

    // Slot k can take new contents unless it and every slot downstream is full and stalled.
    assign load[k]    = out_ready || !(&valid_q[STAGES-1:k]);
    assign valid_d[k] = load[k] ? src_valid : valid_q[k];
    assign data_d[k]  = (load[k] && src_valid) ? src_data : data_q[k];
    assign tag_d[k]   = (load[k] && src_valid) ? src_tag  : tag_q[k];
    assign err_d[k]   = (load[k] && src_valid) ? src_err  : err_q[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      err_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid_q[STAGES-1];
  assign dout      = data_q[STAGES-1];
  assign tag_out   = tag_q[STAGES-1];
  assign err       = err_q[STAGES-1];

endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed bench for des_perm_pipe: one task per scenario, checked against
// hand-computed DES permutation vectors.
module tb_des_perm_pipe;
  import des_pkg::*;

  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [2:0]       mode      = 3'd0;
  logic [63:0]      din       = 64'h0;
  logic [TAG_W-1:0] tag_in    = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [63:0]      dout;
  logic [TAG_W-1:0] tag_out;
  logic             err;

  always #5 clk = ~clk;

  des_perm_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .din       (din),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .tag_out   (tag_out),
    .err       (err)
  );

  int passCount  = 0;
  int checkCount = 0;

  // Known vectors: P, IP, E, FP, PC1, PC2 with their hand-derived results.
  logic [2:0]  kMode [6] = '{3'd3, 3'd0, 3'd2, 3'd1, 3'd4, 3'd5};
  logic [63:0] kDin  [6] = '{64'h0000_0000_8AFE_657E, 64'h0123_4567_89AB_CDEF,
                             64'h0000_0000_F0AA_F0AA, 64'hCC00_CCFF_F0AA_F0AA,
                             64'h1334_5779_9BBC_DFF1, 64'h00E1_9955_FAAC_CF1E};
  logic [63:0] kExp  [6] = '{64'h0000_0000_4EDF_35EC, 64'hCC00_CCFF_F0AA_F0AA,
                             64'h0000_7A15_557A_1555, 64'h0123_4567_89AB_CDEF,
                             64'h00F0_CCAA_F556_678F, 64'h0000_1B02_EFFC_7072};

  logic [2:0]       sMode [8];
  logic [63:0]      sDin  [8];
  logic [TAG_W-1:0] sTag  [8];
  int               sCount;

  logic [63:0]      gDout [8];
  logic [TAG_W-1:0] gTag  [8];
  logic             gErr  [8];
  int               gCyc  [8];
  int               gCount;
  int               missCount;

  // Streams sCount entries back-to-back with out_ready high and records every result seen.
  task automatic applyStimulus();
    gCount    = 0;
    missCount = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (out_valid === 1'b1) begin
        if (gCount < 8) begin
          gDout[gCount] = dout;
          gTag[gCount]  = tag_out;
          gErr[gCount]  = err;
          gCyc[gCount]  = cyc;
        end
        gCount++;
      end
      if (cyc < sCount) begin
        in_valid = 1'b1;
        mode     = sMode[cyc];
        din      = sDin[cyc];
        tag_in   = sTag[cyc];
      end else begin
        in_valid = 1'b0;
        mode     = 3'd0;
        din      = 64'h0;
        tag_in   = '0;
      end
      #1;
      if (cyc < sCount && in_ready !== 1'b1) missCount++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); else passCount++;
    checkCount++; if (dout !== 64'h0) $display("[TB] FAIL reset_dout: got %h want 0", dout); else passCount++;
    checkCount++; if (tag_out !== '0) $display("[TB] FAIL reset_tag: got %h want 0", tag_out); else passCount++;
    checkCount++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", err); else passCount++;
    checkCount++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); else passCount++;
    rst = 1'b0;
    @(posedge clk); #1;
    checkCount++; if (in_ready !== 1'b1) $display("[TB] FAIL post_reset_in_ready: got %b want 1", in_ready); else passCount++;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL post_reset_out_valid: got %b want 0", out_valid); else passCount++;
  endtask

  task automatic test_p_latency();
    sMode[0] = MODE_P; sDin[0] = kDin[0]; sTag[0] = 4'd3; sCount = 1;
    applyStimulus();
    checkCount++; if (missCount !== 0) $display("[TB] FAIL p_accept: got %0d refusals want 0", missCount); else passCount++;
    checkCount++; if (gCount !== 1) $display("[TB] FAIL p_count: got %0d want 1", gCount); else passCount++;
    checkCount++; if (gDout[0] !== 64'h0000_0000_4EDF_35EC) $display("[TB] FAIL p_dout: got %h want 000000004edf35ec", gDout[0]); else passCount++;
    checkCount++; if (gTag[0] !== 4'd3) $display("[TB] FAIL p_tag: got %h want 3", gTag[0]); else passCount++;
    checkCount++; if (gErr[0] !== 1'b0) $display("[TB] FAIL p_err: got %b want 0", gErr[0]); else passCount++;
    checkCount++; if (gCyc[0] !== STAGES) $display("[TB] FAIL p_latency: got %0d want %0d", gCyc[0], STAGES); else passCount++;
  endtask

  task automatic test_back_to_back();
    int idx [3] = '{1, 3, 2};
    logic [TAG_W-1:0] tags [3] = '{4'd1, 4'd2, 4'd5};
    for (int j = 0; j < 3; j++) begin
      sMode[j] = kMode[idx[j]]; sDin[j] = kDin[idx[j]]; sTag[j] = tags[j];
    end
    sCount = 3;
    applyStimulus();
    checkCount++; if (missCount !== 0) $display("[TB] FAIL b2b_accept: got %0d refusals want 0", missCount); else passCount++;
    checkCount++; if (gCount !== 3) $display("[TB] FAIL b2b_count: got %0d want 3", gCount); else passCount++;
    for (int j = 0; j < 3; j++) begin
      checkCount++; if (gDout[j] !== kExp[idx[j]]) $display("[TB] FAIL b2b_dout%0d: got %h want %h", j, gDout[j], kExp[idx[j]]); else passCount++;
      checkCount++; if (gTag[j] !== tags[j]) $display("[TB] FAIL b2b_tag%0d: got %h want %h", j, gTag[j], tags[j]); else passCount++;
      checkCount++; if (gErr[j] !== 1'b0) $display("[TB] FAIL b2b_err%0d: got %b want 0", j, gErr[j]); else passCount++;
      checkCount++; if (gCyc[j] !== j + STAGES) $display("[TB] FAIL b2b_cycle%0d: got %0d want %0d", j, gCyc[j], j + STAGES); else passCount++;
    end
  endtask

  task automatic test_key_schedule();
    logic [TAG_W-1:0] tags [2] = '{4'd9, 4'd10};
    for (int j = 0; j < 2; j++) begin
      sMode[j] = kMode[4 + j]; sDin[j] = kDin[4 + j]; sTag[j] = tags[j];
    end
    sCount = 2;
    applyStimulus();
    checkCount++; if (missCount !== 0) $display("[TB] FAIL key_accept: got %0d refusals want 0", missCount); else passCount++;
    checkCount++; if (gCount !== 2) $display("[TB] FAIL key_count: got %0d want 2", gCount); else passCount++;
    for (int j = 0; j < 2; j++) begin
      checkCount++; if (gDout[j] !== kExp[4 + j]) $display("[TB] FAIL key_dout%0d: got %h want %h", j, gDout[j], kExp[4 + j]); else passCount++;
      checkCount++; if (gTag[j] !== tags[j]) $display("[TB] FAIL key_tag%0d: got %h want %h", j, gTag[j], tags[j]); else passCount++;
      checkCount++; if (gCyc[j] !== j + STAGES) $display("[TB] FAIL key_cycle%0d: got %0d want %0d", j, gCyc[j], j + STAGES); else passCount++;
    end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    int rcv      = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i >= STAGES) begin
        checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_hold_valid%0d: got %b want 1", i, out_valid); else passCount++;
        checkCount++; if (dout !== kExp[0]) $display("[TB] FAIL bp_hold_dout%0d: got %h want %h", i, dout, kExp[0]); else passCount++;
        checkCount++; if (tag_out !== 4'd8) $display("[TB] FAIL bp_hold_tag%0d: got %h want 8", i, tag_out); else passCount++;
      end
      in_valid = 1'b1; mode = kMode[i]; din = kDin[i]; tag_in = TAG_W'(8 + i);
      #1;
      if (in_ready === 1'b1) accepted++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checkCount++; if (accepted !== STAGES) $display("[TB] FAIL bp_accepted: got %0d want %0d", accepted, STAGES); else passCount++;
    checkCount++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready: got %b want 0", in_ready); else passCount++;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (out_valid === 1'b1) begin
        if (rcv < STAGES) begin
          checkCount++; if (dout !== kExp[rcv]) $display("[TB] FAIL bp_drain_dout%0d: got %h want %h", rcv, dout, kExp[rcv]); else passCount++;
          checkCount++; if (tag_out !== TAG_W'(8 + rcv)) $display("[TB] FAIL bp_drain_tag%0d: got %h want %h", rcv, tag_out, TAG_W'(8 + rcv)); else passCount++;
        end
        rcv++;
      end
      @(posedge clk); #1;
    end
    checkCount++; if (rcv !== STAGES) $display("[TB] FAIL bp_drain_count: got %0d want %0d", rcv, STAGES); else passCount++;
  endtask

  task automatic test_illegal_mode();
    sMode[0] = 3'd7;   sDin[0] = 64'hFFFF_FFFF_FFFF_FFFF; sTag[0] = 4'd6;
    sMode[1] = MODE_P; sDin[1] = kDin[0];                 sTag[1] = 4'd7;
    sCount = 2;
    applyStimulus();
    checkCount++; if (gCount !== 2) $display("[TB] FAIL ill_count: got %0d want 2", gCount); else passCount++;
    checkCount++; if (gDout[0] !== 64'h0) $display("[TB] FAIL ill_dout: got %h want 0", gDout[0]); else passCount++;
    checkCount++; if (gErr[0] !== 1'b1) $display("[TB] FAIL ill_err: got %b want 1", gErr[0]); else passCount++;
    checkCount++; if (gTag[0] !== 4'd6) $display("[TB] FAIL ill_tag: got %h want 6", gTag[0]); else passCount++;
    checkCount++; if (gErr[1] !== 1'b0) $display("[TB] FAIL ill_next_err: got %b want 0", gErr[1]); else passCount++;
    checkCount++; if (gDout[1] !== kExp[0]) $display("[TB] FAIL ill_next_dout: got %h want %h", gDout[1], kExp[0]); else passCount++;
    checkCount++; if (gTag[1] !== 4'd7) $display("[TB] FAIL ill_next_tag: got %h want 7", gTag[1]); else passCount++;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int i = 0; i < STAGES + 1; i++) begin
      in_valid = 1'b1; mode = MODE_IP; din = kDin[1]; tag_in = TAG_W'(i + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL mid_full_valid: got %b want 1", out_valid); else passCount++;
    checkCount++; if (in_ready !== 1'b0) $display("[TB] FAIL mid_full_in_ready: got %b want 0", in_ready); else passCount++;
    rst = 1'b1;
    #1;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_rst_valid: got %b want 0", out_valid); else passCount++;
    checkCount++; if (dout !== 64'h0) $display("[TB] FAIL mid_rst_dout: got %h want 0", dout); else passCount++;
    checkCount++; if (tag_out !== '0) $display("[TB] FAIL mid_rst_tag: got %h want 0", tag_out); else passCount++;
    checkCount++; if (err !== 1'b0) $display("[TB] FAIL mid_rst_err: got %b want 0", err); else passCount++;
    checkCount++; if (in_ready !== 1'b1) $display("[TB] FAIL mid_rst_in_ready: got %b want 1", in_ready); else passCount++;
    @(posedge clk); #1;
    rst = 1'b0;
    sMode[0] = MODE_P; sDin[0] = kDin[0]; sTag[0] = 4'd12; sCount = 1;
    applyStimulus();
    checkCount++; if (gCount !== 1) $display("[TB] FAIL mid_after_count: got %0d want 1", gCount); else passCount++;
    checkCount++; if (gDout[0] !== kExp[0]) $display("[TB] FAIL mid_after_dout: got %h want %h", gDout[0], kExp[0]); else passCount++;
    checkCount++; if (gTag[0] !== 4'd12) $display("[TB] FAIL mid_after_tag: got %h want c", gTag[0]); else passCount++;
    checkCount++; if (gCyc[0] !== STAGES) $display("[TB] FAIL mid_after_latency: got %0d want %0d", gCyc[0], STAGES); else passCount++;
  endtask

  initial begin
    test_reset();
    test_p_latency();
    test_back_to_back();
    test_key_schedule();
    test_backpressure();
    test_illegal_mode();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/des_perm_pipe.md
# des_perm_pipe

Parametrised, pipelined DES bit-permutation engine. It generalises the fixed 32-bit straight P-box into one runtime-selectable unit covering every DES permutation and expansion: IP, FP (IP⁻¹), E, P, PC-1 and PC-2. A valid/ready handshake with back-pressure lets the round datapath and key schedule share one permutation resource. A tag travels alongside each result.

## Interface
- STAGES, 2: pipeline register stages, 1–4; sets latency.
- TAG_W, 4: width of the user tag carried with each transfer, ≥1.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input transfer request.
- in_ready  out  1  engine can accept this cycle.
- mode  in  3  0 IP, 1 FP, 2 E, 3 P, 4 PC1, 5 PC2, 6–7 illegal.
- din  in  [0:63]  operand, MSB-first numbering (bit 0 = DES bit 1); narrow operands are right-aligned.
- tag_in  in  TAG_W  user tag.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- dout  out  [0:63]  result, right-aligned, unused upper bits zero.
- tag_out  out  TAG_W  tag of the result.
- err  out  1  result came from an illegal mode.

## Operation
- Operand and result alignment per mode:
  - IP/FP: din[0:63] → dout[0:63].
  - E: din[32:63] → dout[16:63].
  - P: din[32:63] → dout[32:63].
  - PC1: din[0:63] (parity bits dropped) → dout[8:63].
  - PC2: din[8:63] → dout[16:63].
- Permutation is applied combinationally before the first stage register. Standard FIPS 46-3 tables, 1-based indices mapped to bit index − 1 of the operand field.
- Illegal mode: dout = 0, err = 1; the transfer otherwise flows normally.
- Pipeline is STAGES slots, each holding {valid, data, tag, err}.
- Slot k loads from slot k−1 (slot 0 from the input) when slot k is empty or slot k is advancing. Bubbles therefore collapse.
- Last slot advances on out_valid && out_ready.
- in_ready = !slot0.valid || slot0 advancing. This path is combinational from out_ready through the chain; no registered skid.
- An input transfer occurs on in_valid && in_ready. An output transfer occurs on out_valid && out_ready.
- Simultaneous input and output transfers in a full pipe sustain one result per cycle.
- Data, tag and err are held stable while out_valid && !out_ready. mode and din are not sampled unless an input transfer occurs.

## Timing
- Reset (asynchronous, any time, including mid-stream):
  - All slot valids clear immediately; in-flight results are discarded.
  - out_valid=0, dout=0, tag_out=0, err=0.
  - in_ready=1 once reset releases (also 1 combinationally during reset).
- Latency: an input accepted at edge n appears with out_valid=1 after edge n+STAGES−1 (i.e. visible STAGES−1 cycles after acceptance, next-cycle when STAGES=1), provided no stall.
- Throughput is 1 per cycle with out_ready held high.
- Capacity is STAGES results.
- Full pipe, out_ready=0: in_ready=0 and nothing is lost.
- Empty pipe: out_valid=0; dout holds its last value, and the bench ignores it.
- Ordering is strictly FIFO; tags are never reordered.

## Structure
- Package des_pkg holds:
  - mode localparams MODE_IP..MODE_PC2;
  - the six permutation tables as constant arrays (IP 64, FP 64, E 48, P 32, PC1 56, PC2 48 entries).
- One sub-module, des_perm_sel: the purely combinational mode → permuted-word function with err. The top holds only the pipeline/handshake logic.
- The existing straight_pbox is not instantiated. P mode must be bit-identical to it.

## Test plan
- P mode, din low word 32'h8afe657e, tag 3 → dout = 64'h0000_0000_4EDF_35EC, tag_out 3, err 0, exactly STAGES−1 cycles after acceptance.
- Back-to-back with out_ready=1:
  - IP of 64'h0123456789ABCDEF → 64'hCC00CCFFF0AAF0AA.
  - FP of that result → 64'h0123456789ABCDEF.
  - E of 32'hF0AAF0AA → 48'h7A15557A1555 (right-aligned).
  - Results arrive on consecutive cycles in order.
- Key schedule, consecutive inputs:
  - PC1 of 64'h133457799BBCDFF1 → 56'hF0CCAAF556678F.
  - PC2 of 56'hE19955FAACCF1E → 48'h1B02EFFC7072.
- Back-pressure: hold out_ready=0 and offer 6 inputs.
  - Exactly STAGES are accepted, then in_ready=0, and dout/tag_out stay stable.
  - Release: all STAGES results drain in order with no loss or duplication.
- Illegal mode 7 with din 64'hFFFF_FFFF_FFFF_FFFF → dout 0, err 1. The next legal transfer has err 0.
- Assert rst for 1 cycle with the pipe full and stalled:
  - out_valid drops within the reset cycle; all outputs are zero and in_ready=1.
  - After release, a fresh P-mode vector produces the correct result with the normal latency.
